// File: rtl/usb_pkg.sv
// Shared USB block constants used by the RX data path.
// Depth, pointer/occupancy widths and byte width for the RX data buffer.
package usb_pkg;

    localparam int RX_BUF_DEPTH = 64;
    localparam int RX_BUF_PTR_W = 6;
    localparam int RX_BUF_OCC_W = 7;
    localparam int BYTE_W       = 8;

endpackage

// File: rtl/rx_buf_mem.sv
// RX buffer storage: DEPTH x WIDTH flop array, synchronous write, indexed read.
// No reset on the array; contents persist through flush and reset.
module rx_buf_mem #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/rx_data_buffer.sv
// USB RX data buffer: byte FIFO between the RX shift register and the AHB side.
// Optional sticky overflow/underflow flags are built only with RX_BUF_ERR_FLAGS_EN defined.
module rx_data_buffer
    import usb_pkg::*;
#(
    parameter int DEPTH = RX_BUF_DEPTH,
    parameter int WIDTH = BYTE_W
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   flush,
    input  logic                   store_rx_data,
    input  logic [WIDTH-1:0]       rx_packet_data,
    input  logic                   get_rx_data,
    output logic [WIDTH-1:0]       rx_data,
    output logic [$clog2(DEPTH):0] buffer_occupancy,
    output logic                   buffer_full,
    output logic                   buffer_empty,
    output logic                   overflow_err,
    output logic                   underflow_err
);

    localparam int PTR_W = (DEPTH == RX_BUF_DEPTH) ? RX_BUF_PTR_W : $clog2(DEPTH);
    localparam int OCC_W = (DEPTH == RX_BUF_DEPTH) ? RX_BUF_OCC_W : $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic [WIDTH-1:0] mem_rd_data;
    logic             full_w;
    logic             empty_w;
    logic             wr_acc;
    logic             rd_acc;

    assign full_w  = (occ_q == OCC_W'(DEPTH));
    assign empty_w = (occ_q == '0);

    // Acceptance uses pre-edge occupancy, so a same-cycle read never frees room for a write.
    assign wr_acc = store_rx_data && !flush && !full_w;
    assign rd_acc = get_rx_data   && !flush && !empty_w;

    rx_buf_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wptr_q),
        .wr_data (rx_packet_data),
        .rd_addr (rptr_q),
        .rd_data (mem_rd_data)
    );

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        occ_d     = occ_q;
        rx_data_d = rx_data_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            occ_d  = '0;
        end else begin
            if (wr_acc) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (rd_acc) begin
                rptr_d    = rptr_q + PTR_W'(1);
                rx_data_d = mem_rd_data;
            end
            case ({wr_acc, rd_acc})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            occ_q     <= '0;
            rx_data_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            occ_q     <= occ_d;
            rx_data_q <= rx_data_d;
        end
    end

`ifdef RX_BUF_ERR_FLAGS_EN
    logic ovf_q;
    logic unf_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (flush) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (store_rx_data && full_w) begin
                ovf_q <= 1'b1;
            end
            if (get_rx_data && empty_w) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;
`else
    assign overflow_err  = 1'b0;
    assign underflow_err = 1'b0;
`endif

    assign rx_data          = rx_data_q;
    assign buffer_occupancy = occ_q;
    assign buffer_full      = full_w;
    assign buffer_empty     = empty_w;

endmodule

// File: tb/tb_rx_data_buffer.sv
// Scoreboard bench for rx_data_buffer: stimulus pushes expected read bytes,
// a monitor pops and compares them one cycle after each accepted read.
module tb_rx_data_buffer;

`ifdef RX_BUF_ERR_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic       clk;
    logic       n_rst;
    logic       flush;
    logic       store_rx_data;
    logic [7:0] rx_packet_data;
    logic       get_rx_data;
    logic [7:0] rx_data;
    logic [6:0] buffer_occupancy;
    logic       buffer_full;
    logic       buffer_empty;
    logic       overflow_err;
    logic       underflow_err;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] mdl  [$];
    logic [7:0] expq [$];
    logic       rd_issue;
    logic       rd_issue_q;
    bit         ovf_m;
    bit         unf_m;

    rx_data_buffer dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .flush            (flush),
        .store_rx_data    (store_rx_data),
        .rx_packet_data   (rx_packet_data),
        .get_rx_data      (get_rx_data),
        .rx_data          (rx_data),
        .buffer_occupancy (buffer_occupancy),
        .buffer_full      (buffer_full),
        .buffer_empty     (buffer_empty),
        .overflow_err     (overflow_err),
        .underflow_err    (underflow_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_occ"},   32'(buffer_occupancy), 32'(mdl.size()));
        chk({tag, "_full"},  32'(buffer_full),      32'(mdl.size() == 64));
        chk({tag, "_empty"}, 32'(buffer_empty),     32'(mdl.size() == 0));
        chk({tag, "_ovf"},   32'(overflow_err),     32'(ovf_m));
        chk({tag, "_unf"},   32'(underflow_err),    32'(unf_m));
    endtask

    // Drive one cycle at the falling edge and update the reference model.
    task automatic step(input bit st, input logic [7:0] dat, input bit gt, input bit fl);
        int sz;
        bit racc;
        bit wacc;
        store_rx_data  = st;
        rx_packet_data = dat;
        get_rx_data    = gt;
        flush          = fl;
        if (fl) begin
            mdl.delete();
            ovf_m    = 1'b0;
            unf_m    = 1'b0;
            rd_issue = 1'b0;
        end else begin
            sz   = mdl.size();
            racc = gt && (sz > 0);
            wacc = st && (sz < 64);
            if (FLAGS_ON && st && !wacc) ovf_m = 1'b1;
            if (FLAGS_ON && gt && !racc) unf_m = 1'b1;
            rd_issue = racc;
            if (racc) expq.push_back(mdl.pop_front());
            if (wacc) mdl.push_back(dat);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) rd_issue_q <= 1'b0;
        else        rd_issue_q <= rd_issue;
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (rd_issue_q) begin
            n_vec++;
            if (expq.size() == 0) begin
                n_bad++;
                $display("FAIL rd_data: got %0h expected none pending", rx_data);
            end else begin
                e = expq.pop_front();
                if (rx_data !== e) begin
                    n_bad++;
                    $display("FAIL rd_data: got %0h expected %0h (t=%0t)", rx_data, e, $time);
                end
            end
        end
    end

    initial begin
        n_rst          = 1'b0;
        flush          = 1'b0;
        store_rx_data  = 1'b0;
        get_rx_data    = 1'b0;
        rx_packet_data = 8'h00;
        rd_issue       = 1'b0;
        ovf_m          = 1'b0;
        unf_m          = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_rx_data", 32'(rx_data), 32'h00);
        check_status("reset");
        n_rst = 1'b1;
        @(negedge clk);

        // Two bytes in, two bytes out
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        idle();
        chk("t1_occ2", 32'(buffer_occupancy), 32'd2);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        chk("t1_last_rd", 32'(rx_data), 32'h3C);
        chk("t1_empty", 32'(buffer_empty), 32'd1);
        check_status("t1");

        // Fill to 64, drop the 65th, drain in order
        for (int i = 0; i < 64; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        idle();
        chk("t2_occ64", 32'(buffer_occupancy), 32'd64);
        chk("t2_full", 32'(buffer_full), 32'd1);
        chk("t2_ovf", 32'(overflow_err), 32'(FLAGS_ON));
        for (int i = 0; i < 64; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        chk("t2_last_rd", 32'(rx_data), 32'd63);
        check_status("t2");

        // Simultaneous store/get across pointer wrap
        for (int i = 0; i < 10; i++) step(1'b1, 8'(100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b1, 8'(110 + i), 1'b1, 1'b0);
        idle();
        chk("t3_occ10", 32'(buffer_occupancy), 32'd10);
        chk("t3_last_rd", 32'(rx_data), 32'd199);
        check_status("t3");
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        check_status("t3_drain");

        // Flush with store and get asserted
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        chk("t4_pre_rd", 32'(rx_data), 32'h40);
        step(1'b1, 8'hEE, 1'b1, 1'b1);
        chk("t4_occ0", 32'(buffer_occupancy), 32'd0);
        chk("t4_empty", 32'(buffer_empty), 32'd1);
        chk("t4_rx_hold", 32'(rx_data), 32'h40);
        chk("t4_ovf_clr", 32'(overflow_err), 32'd0);
        chk("t4_unf_clr", 32'(underflow_err), 32'd0);
        idle();

        // Read while empty
        step(1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        chk("t5_rx_hold", 32'(rx_data), 32'h40);
        chk("t5_occ0", 32'(buffer_occupancy), 32'd0);
        chk("t5_unf", 32'(underflow_err), 32'(FLAGS_ON));

        // Async reset mid-fill
        for (int i = 0; i < 30; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        chk("t6_occ30", 32'(buffer_occupancy), 32'd30);
        store_rx_data  = 1'b1;
        rx_packet_data = 8'hC3;
        #2 n_rst = 1'b0;
        mdl.delete();
        expq.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        #1;
        chk("t6_rst_rx", 32'(rx_data), 32'h00);
        check_status("t6_rst");
        store_rx_data = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        chk("t6_new_rd", 32'(rx_data), 32'h5A);
        check_status("t6_end");

        idle();
        chk("sb_drained", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
